spi_slave_param: RTL and testbench



---
 rtl/spi_slave_param_pkg.sv | 24 ++
 rtl/spi_slave_param_tx_shifter.sv | 58 +++++
 rtl/spi_slave_param.sv | 143 ++++++++++++++
 tb/tb_spi_slave_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_param_pkg.sv
// Shared types and helpers for the parametrised SPI slave.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_WRITE,
    ST_READ_ADD,
    ST_READ_DATA,
    ST_TX_WAIT,
    ST_TX_SHIFT,
    ST_DONE
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int unsigned frame_w(input int unsigned data_w);
    return data_w + 32'd2;
  endfunction

endpackage

// File: rtl/spi_slave_param_tx_shifter.sv
// MISO read-data shifter: loads a word, drives it MSB first, flags the last bit.
module spi_tx_shifter #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear) begin
      active_d = 1'b0;
    end else if (load) begin
      sr_d     = data;
      cnt_d    = CNT_W'(DATA_W - 1);
      active_d = 1'b1;
    end else if (shift && active_q) begin
      // bit 0 stays on the wire for one full cycle before going idle
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign miso = active_q ? sr_q[DATA_W-1] : MISO_IDLE;
  assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave (frame = 2-bit command + DATA_W payload).
// Define SPI_SLAVE_FRAME_ERR_EN to build aborted-frame detection on frame_err.
module spi_slave_param #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err
);

  import spi_pkg::*;

  localparam int unsigned FRAME_W = frame_w(DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic               tx_load, tx_shift, tx_clear, tx_done;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_load        = 1'b0;
    tx_shift       = 1'b0;
    tx_clear       = 1'b0;
    if (state_q != ST_IDLE && SS_n) begin
      state_d = ST_IDLE;
      if (state_q inside {ST_TX_WAIT, ST_TX_SHIFT}) begin
        tx_clear       = 1'b1;
        rd_addr_seen_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: if (!SS_n) state_d = ST_CHK_CMD;
        ST_CHK_CMD: begin
          rx_data_d[FRAME_W-1] = MOSI;
          cnt_d                = CNT_W'(FRAME_W - 1);
          // read sequencing follows the internal flag, not the second command bit
          if (MOSI == CMD_RD_ADDR[1])
            state_d = rd_addr_seen_q ? ST_READ_DATA : ST_READ_ADD;
          else
            state_d = ST_WRITE;
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          rx_data_d[cnt_q - CNT_W'(1)] = MOSI;
          cnt_d                        = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rx_valid_d = 1'b1;
            if (state_q == ST_READ_DATA) begin
              state_d = ST_TX_WAIT;
            end else begin
              state_d = ST_DONE;
              if (state_q == ST_READ_ADD) rd_addr_seen_d = 1'b1;
            end
          end
        end
        ST_TX_WAIT: begin
          if (tx_valid) begin
            tx_load = 1'b1;
            state_d = ST_TX_SHIFT;
          end
        end
        ST_TX_SHIFT: begin
          tx_shift = 1'b1;
          if (tx_done) begin
            rd_addr_seen_d = 1'b0;
            state_d        = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  spi_tx_shifter #(
    .DATA_W   (DATA_W),
    .MISO_IDLE(MISO_IDLE)
  ) u_tx_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tx_load),
    .shift(tx_shift),
    .clear(tx_clear),
    .data (tx_data),
    .miso (MISO),
    .done (tx_done)
  );

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = SS_n && (state_q inside {ST_CHK_CMD, ST_WRITE, ST_READ_ADD,
                                           ST_READ_DATA, ST_TX_WAIT, ST_TX_SHIFT});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param (DATA_W=8 and DATA_W=16 instances).
module tb_spi_slave_param;

  logic        clk;
  logic        rst_n;
  logic        ss8_n, ss16_n, mosi, tx_valid;
  logic [15:0] tx_data;
  logic        miso8, rx_valid8, busy8, fe8;
  logic [9:0]  rx_data8;
  logic        miso16, rx_valid16, busy16, fe16;
  logic [17:0] rx_data16;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          m_seen[2];

  localparam logic IDLE8  = 1'b0;
  localparam logic IDLE16 = 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  spi_slave_param #(.DATA_W(8), .MISO_IDLE(IDLE8)) dut8 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss8_n), .MOSI(mosi), .MISO(miso8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .busy(busy8), .frame_err(fe8)
  );

  spi_slave_param #(.DATA_W(16), .MISO_IDLE(IDLE16)) dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss16_n), .MOSI(mosi), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy16), .frame_err(fe16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish before 500000", $time);
    $fatal(1);
  end

  function automatic logic miso_of(input bit w); return w ? miso16 : miso8; endfunction
  function automatic logic rv_of(input bit w); return w ? rx_valid16 : rx_valid8; endfunction
  function automatic logic busy_of(input bit w); return w ? busy16 : busy8; endfunction
  function automatic logic fe_of(input bit w); return w ? fe16 : fe8; endfunction
  function automatic logic [17:0] rd_of(input bit w);
    return w ? rx_data16 : {8'h00, rx_data8};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ss(input bit w, input logic v);
    if (w) ss16_n = v;
    else   ss8_n  = v;
  endtask

  // mode 0: normal, 1: SS_n rises in TX_WAIT, 2: reset mid TX_SHIFT
  task automatic do_frame(input bit w, input logic [17:0] frame, input int mode,
                          input int delay, input logic [15:0] txd);
    int          fw, dw;
    bit          to_tx;
    logic        idle_lvl;
    logic [17:0] exp_rd;
    fw       = w ? 18 : 10;
    dw       = fw - 2;
    idle_lvl = w ? IDLE16 : IDLE8;
    exp_rd   = frame & ((18'h1 << fw) - 18'h1);
    to_tx    = frame[fw-1] && m_seen[w];

    @(negedge clk);
    set_ss(w, 1'b0);
    for (int k = 1; k <= fw; k++) begin
      @(negedge clk);
      chk("busy_in_frame", busy_of(w), 1);
      chk("rx_valid_early", rv_of(w), 0);
      mosi = frame[fw-k];
    end
    @(negedge clk);
    mosi = 1'($urandom);
    chk("rx_valid_pulse", rv_of(w), 1);
    chk("rx_data", rd_of(w), exp_rd);
    if (frame[fw-1] && !m_seen[w]) m_seen[w] = 1'b1;

    if (!to_tx) begin
      tx_data  = 16'($urandom);
      tx_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("rx_valid_end", rv_of(w), 0);
        chk("miso_no_tx", miso_of(w), idle_lvl);
        chk("busy_done", busy_of(w), 1);
      end
      tx_valid = 1'b0;
    end else begin
      for (int j = 0; j < delay; j++) begin
        @(negedge clk);
        chk("rx_valid_end", rv_of(w), 0);
        chk("miso_tx_wait", miso_of(w), idle_lvl);
      end
      if (mode == 1) begin
        set_ss(w, 1'b1);
        @(negedge clk);
        chk("busy_abort_wait", busy_of(w), 0);
        chk("miso_abort_wait", miso_of(w), idle_lvl);
        chk("frame_err_wait", fe_of(w), FE_EXP);
        m_seen[w] = 1'b0;
        @(negedge clk);
        chk("frame_err_clear", fe_of(w), 0);
        return;
      end
      tx_data  = txd;
      tx_valid = 1'b1;
      for (int i = 0; i < dw; i++) begin
        @(negedge clk);
        tx_valid = 1'b0;
        chk("rx_valid_end", rv_of(w), 0);
        chk("miso_bit", miso_of(w), txd[dw-1-i]);
        if (mode == 2 && i == 3) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_miso", miso_of(w), idle_lvl);
          chk("rst_busy", busy_of(w), 0);
          chk("rst_rx_valid", rv_of(w), 0);
          chk("rst_frame_err", fe_of(w), 0);
          chk("rst_rx_data", rd_of(w), 0);
          m_seen[0] = 1'b0;
          m_seen[1] = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          set_ss(w, 1'b1);
          @(negedge clk);
          chk("busy_after_rst", busy_of(w), 0);
          return;
        end
      end
      @(negedge clk);
      chk("miso_after_tx", miso_of(w), idle_lvl);
      chk("busy_after_tx", busy_of(w), 1);
      m_seen[w] = 1'b0;
    end

    set_ss(w, 1'b1);
    @(negedge clk);
    chk("busy_release", busy_of(w), 0);
    chk("frame_err_normal", fe_of(w), 0);
    chk("miso_release", miso_of(w), idle_lvl);
  endtask

  task automatic do_abort(input bit w, input logic [17:0] frame, input int nbits);
    int fw;
    fw = w ? 18 : 10;
    @(negedge clk);
    set_ss(w, 1'b0);
    for (int k = 1; k <= nbits; k++) begin
      @(negedge clk);
      mosi = frame[fw-k];
    end
    @(negedge clk);
    set_ss(w, 1'b1);
    chk("abort_rx_valid", rv_of(w), 0);
    @(negedge clk);
    chk("abort_busy", busy_of(w), 0);
    chk("abort_rx_valid", rv_of(w), 0);
    chk("abort_frame_err", fe_of(w), FE_EXP);
    @(negedge clk);
    chk("abort_frame_err_clear", fe_of(w), 0);
    chk("abort_rx_valid", rv_of(w), 0);
  endtask

  initial begin
    logic [17:0] f;
    rst_n    = 1'b0;
    ss8_n    = 1'b1;
    ss16_n   = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    m_seen[0] = 1'b0;
    m_seen[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_miso8", miso8, IDLE8);
    chk("reset_miso16", miso16, IDLE16);
    chk("reset_rx_data", rx_data8, 0);
    chk("reset_rx_valid", rx_valid8, 0);
    chk("reset_busy", busy8, 0);
    chk("reset_frame_err", fe8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed DATA_W=8 sequence
    do_frame(0, 18'h0A5, 0, 0, 16'h0);
    do_frame(0, 18'h1F0, 0, 0, 16'h0);
    do_frame(0, 18'h203, 0, 0, 16'h0);
    do_frame(0, 18'h35A, 0, 3, 16'h00C3);
    do_frame(0, 18'h3C4, 0, 0, 16'h0);
    do_abort(0, 18'h155, 5);
    do_frame(0, 18'h12E, 0, 0, 16'h0);
    do_abort(0, 18'h000, 0);

    // randomized DATA_W=8 frames
    for (int n = 0; n < 10; n++) begin
      f = 18'($urandom) & 18'h3FF;
      do_frame(0, f, 0, int'($urandom_range(0, 4)), 16'($urandom));
    end

    // abort while waiting for tx_valid
    if (!m_seen[0]) do_frame(0, 18'h2AA, 0, 0, 16'h0);
    do_frame(0, 18'h3FF, 1, 2, 16'h0);
    do_frame(0, 18'h300, 0, 0, 16'h0);

    // asynchronous reset in the middle of TX_SHIFT
    if (!m_seen[0]) do_frame(0, 18'h211, 0, 0, 16'h0);
    do_frame(0, 18'h3A5, 2, 1, 16'h00B6);
    do_frame(0, 18'h3FF, 0, 0, 16'h0);

    // DATA_W=16 instance
    do_frame(1, 18'h21234, 0, 0, 16'h0);
    do_frame(1, 18'h30000, 0, 2, 16'hBEEF);
    do_abort(1, 18'h2AAAA, 9);
    for (int n = 0; n < 4; n++) begin
      f = 18'($urandom);
      do_frame(1, f, 0, int'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
